// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with valid/ready load and serial ports.
// Accepts one WIDTH-bit word while idle and emits it one bit per accepted beat.
`timescale 1ns/1ps

module piso_shift_reg #(
    parameter int unsigned WIDTH     = 64,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] d,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sout_last,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;

    logic               w_beat;
    logic               w_at_last;
    logic [WIDTH-1:0]   w_shreg_next;

    assign w_beat    = (r_state == SHIFT) && sout_ready;
    assign w_at_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Move the next bit into the output position, back-filling with zero.
    assign w_shreg_next = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shreg[WIDTH-1:1]};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load_valid) begin
                        r_shreg <= d;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_beat) begin
                        if (w_at_last) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_shreg <= w_shreg_next;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Ready is masked by reset so no word is offered acceptance during Rst.
    assign load_ready = (r_state == IDLE) && !Rst;
    assign sout_valid = (r_state == SHIFT);
    assign sout       = (r_state == SHIFT) &&
                        (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
    assign sout_last  = (r_state == SHIFT) && w_at_last;
    assign done       = r_done;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: three configurations (8 LSB-first,
// 8 MSB-first, 64 LSB-first) checked against a bit-index reference model.
`timescale 1ns/1ps

module tb_piso_shift_reg;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [2:0]  lv;
    logic [2:0]  sr;
    logic [2:0]  lr;
    logic [2:0]  so;
    logic [2:0]  sv;
    logic [2:0]  sl;
    logic [2:0]  dn;
    logic [63:0] dd [3];

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
        .Clk(Clk), .Rst(Rst), .load_valid(lv[0]), .load_ready(lr[0]), .d(dd[0][7:0]),
        .sout(so[0]), .sout_valid(sv[0]), .sout_ready(sr[0]), .sout_last(sl[0]), .done(dn[0]));

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
        .Clk(Clk), .Rst(Rst), .load_valid(lv[1]), .load_ready(lr[1]), .d(dd[1][7:0]),
        .sout(so[1]), .sout_valid(sv[1]), .sout_ready(sr[1]), .sout_last(sl[1]), .done(dn[1]));

    piso_shift_reg #(.WIDTH(64), .MSB_FIRST(1'b0)) u_l64 (
        .Clk(Clk), .Rst(Rst), .load_valid(lv[2]), .load_ready(lr[2]), .d(dd[2]),
        .sout(so[2]), .sout_valid(sv[2]), .sout_ready(sr[2]), .sout_last(sl[2]), .done(dn[2]));

    function automatic int wid(input int s);
        return (s == 2) ? 64 : 8;
    endfunction

    function automatic bit msb(input int s);
        return (s == 1);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Offer a word while idle; optionally keep load_valid high afterwards.
    task automatic accept(input int s, input logic [63:0] w, input bit hold);
        chk1("accept_ready", lr[s], 1'b1);
        lv[s] = 1'b1;
        dd[s] = w;
        tick();
        if (!hold) begin
            lv[s] = 1'b0;
            dd[s] = {$urandom, $urandom};
        end
    endtask

    // Model: beat k carries w[k] (LSB-first) or w[W-1-k] (MSB-first).
    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic shift_phase(input int s, input logic [63:0] w, input int mode);
        int   k;
        int   c;
        int   W;
        logic eb;
        bit   r;
        k = 0;
        c = 0;
        W = wid(s);
        while (k < W && c < 4 * W + 16) begin
            eb = msb(s) ? w[W-1-k] : w[k];
            case (mode)
                0:       r = 1'b1;
                1:       r = ((c % 4) == 0) || ((c % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            sr[s] = r;
            chk1("sout_valid", sv[s], 1'b1);
            chk1("sout_bit", so[s], eb);
            chk1("sout_last", sl[s], k == W - 1);
            chk1("load_ready_busy", lr[s], 1'b0);
            chk1("done_busy", dn[s], 1'b0);
            tick();
            if (r) k++;
            c++;
        end
        chk64("beat_count", 64'(k), 64'(W));
        sr[s] = 1'($urandom_range(0, 1));
        chk1("done_pulse", dn[s], 1'b1);
        chk1("sout_valid_end", sv[s], 1'b0);
        chk1("sout_idle", so[s], 1'b0);
        chk1("load_ready_end", lr[s], 1'b1);
    endtask

    task automatic idle_cycle(input int s);
        tick();
        chk1("done_once", dn[s], 1'b0);
        chk1("idle_valid", sv[s], 1'b0);
        chk1("idle_ready", lr[s], 1'b1);
    endtask

    initial begin
        logic [63:0] w;
        int          s;

        // Reset held with load_valid asserted on every instance.
        Rst = 1'b1;
        lv  = 3'b111;
        sr  = 3'b111;
        for (int i = 0; i < 3; i++) dd[i] = {$urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                chk1("rst_load_ready", lr[i], 1'b0);
                chk1("rst_sout_valid", sv[i], 1'b0);
                chk1("rst_sout", so[i], 1'b0);
                chk1("rst_done", dn[i], 1'b0);
            end
        end
        Rst = 1'b0;
        lv  = 3'b000;
        #1;
        for (int i = 0; i < 3; i++) chk1("post_rst_ready", lr[i], 1'b1);
        tick();

        // Basic LSB-first and MSB-first with continuous ready.
        accept(0, 64'hA5, 1'b0);
        shift_phase(0, 64'hA5, 0);
        idle_cycle(0);
        accept(1, 64'hA5, 1'b0);
        shift_phase(1, 64'hA5, 0);
        idle_cycle(1);
        accept(1, 64'h01, 1'b0);
        shift_phase(1, 64'h01, 0);
        idle_cycle(1);

        // Wide word under a 1,0,0,1 ready pattern.
        accept(2, 64'h8000_0000_0000_0001, 1'b0);
        shift_phase(2, 64'h8000_0000_0000_0001, 1);
        idle_cycle(2);

        // load_valid held through SHIFT with d=0; second word taken only when idle.
        accept(0, 64'hFF, 1'b1);
        dd[0] = 64'h0;
        shift_phase(0, 64'hFF, 0);
        tick();
        lv[0] = 1'b0;
        shift_phase(0, 64'h00, 0);
        idle_cycle(0);

        // Reset after three beats abandons the word.
        accept(0, 64'hF0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sr[0] = 1'b1;
            chk1("pre_rst_bit", so[0], 1'b0);
            tick();
        end
        Rst = 1'b1;
        #1;
        chk1("midrst_ready_low", lr[0], 1'b0);
        tick();
        Rst = 1'b0;
        #1;
        chk1("midrst_valid", sv[0], 1'b0);
        chk1("midrst_done", dn[0], 1'b0);
        chk1("midrst_ready", lr[0], 1'b1);
        accept(0, 64'h0F, 1'b0);
        shift_phase(0, 64'h0F, 0);
        idle_cycle(0);

        // Random words with random backpressure across all configurations.
        for (int n = 0; n < 9; n++) begin
            s = $urandom_range(0, 2);
            w = {$urandom, $urandom};
            if (wid(s) == 8) w = w & 64'hFF;
            accept(s, w, 1'b0);
            shift_phase(s, w, 2);
            idle_cycle(s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parallel-in, serial-out shift register; the transmit-side counterpart of the datapath parallel register.
- Accepts a WIDTH-bit word through a valid/ready load handshake, then emits it one bit per accepted beat on a valid/ready serial port.
- Sits between register-file/datapath outputs and any bit-serial consumer, such as a serial link or the matching serial-in/parallel-out capture block.

Parameters:
- WIDTH, 64, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 0, bit order: 0 sends bit 0 first; 1 sends bit WIDTH-1 first.

Ports:
- Clk  input  1  clock; all state changes on posedge Clk.
- Rst  input  1  reset, synchronous, active-high.
- load_valid  input  1  producer has a word on d.
- load_ready  output  1  block can accept a word this cycle.
- d  input  WIDTH  parallel word to transmit.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  consumer accepts sout this cycle.
- sout_last  output  1  current bit is the final bit of the word.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Internal state: FSM {IDLE, SHIFT}, shift register shreg[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH).
- Reset (Rst=1 at posedge):
  - state=IDLE, shreg=0, cnt=0, done=0.
  - Rst has priority over every other input.
  - A reset mid-word abandons that word; no further bits are emitted.
- load_ready = (state==IDLE) && !Rst, combinational.
  - Reads 0 during any cycle with Rst=1.
  - Reads 1 in the first cycle after Rst is released.
- sout_valid = (state==SHIFT).
- sout = MSB_FIRST ? shreg[WIDTH-1] : shreg[0]; reads 0 whenever state==IDLE.
- sout_last = (state==SHIFT) && (cnt==WIDTH-1).
- IDLE:
  - On load_valid && load_ready: shreg<=d, cnt<=0, state<=SHIFT.
  - The first bit is visible on sout in the next cycle (load-to-first-bit latency = 1 cycle).
  - Otherwise hold state.
- SHIFT:
  - Beat = sout_valid && sout_ready.
  - On a beat with cnt < WIDTH-1:
    - Shift shreg one position toward the output end, filling with 0 (right shift when MSB_FIRST=0, left shift when MSB_FIRST=1).
    - cnt<=cnt+1.
  - On a beat with cnt==WIDTH-1: state<=IDLE, cnt<=0, done<=1 for exactly one cycle.
  - With sout_ready=0: sout, sout_last, shreg and cnt hold indefinitely. No bit is dropped or repeated.
- done: registered; 1 only in the cycle after the last-bit beat, 0 otherwise.
- Throughput:
  - Minimum word period is WIDTH+1 cycles: WIDTH beats plus one IDLE cycle for the next load.
  - Back-to-back load on the last-beat cycle is not supported, because load_ready=0 in SHIFT.
- load_valid in SHIFT is ignored; d is not sampled outside the IDLE accept cycle.
- X on d is permitted when load_valid=0.
- Exact WIDTH bits are sent per word; the counter never wraps mid-word.

Test Plan:
- Reset: hold Rst=1 for 3 cycles with load_valid=1 -> load_ready=0, sout_valid=0, sout=0, done=0 throughout. After release, load_ready=1 in the first cycle.
- Basic LSB-first (WIDTH=8, MSB_FIRST=0): load d=8'hA5, sout_ready=1 constant -> sout sequence 1,0,1,0,0,1,0,1 on cycles 1..8 after accept. sout_last=1 only on cycle 8. done=1 on cycle 9. load_ready=1 on cycle 9.
- MSB-first (WIDTH=8, MSB_FIRST=1): load d=8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 (MSB to LSB). Then load 8'h01 -> seven 0s followed by a 1, with sout_last on the 1.
- Backpressure (WIDTH=64, MSB_FIRST=0): load 64'h8000_0000_0000_0001. Toggle sout_ready 1,0,0,1 pattern -> exactly 64 beats; bit 0 = 1, bits 1..62 = 0, bit 63 = 1. sout is stable across every ready-low cycle. done pulses once.
- Ignored load in SHIFT (WIDTH=8): load 8'hFF, then assert load_valid with d=8'h00 during shifting -> all 8 emitted bits = 1. The second word is accepted only once load_ready=1, and then emits 8 zeros.
- Reset mid-word (WIDTH=8): load 8'hF0, accept 3 beats, then Rst=1 for 1 cycle -> next cycle sout_valid=0, done=0, load_ready=1. A new load of 8'h0F emits 1,1,1,1,0,0,0,0 from a fresh cnt=0.
